// File: rtl/microseq_pkg.sv
// Shared constants and types for the SAP-style microsequencer: control-bit map, opcodes, microcode words.
// Optional build macro used by the top level: MICROSEQ_FLAG_LATCH_EN.
package microseq_pkg;

  localparam int CW_WIDTH = 16;

  localparam int CB_HLT      = 15;
  localparam int CB_MARWA    = 14;
  localparam int CB_RAMWA    = 13;
  localparam int CB_RAMOA    = 12;
  localparam int CB_INREGOA  = 11;
  localparam int CB_INREGWA  = 10;
  localparam int CB_AWA      = 9;
  localparam int CB_AOA      = 8;
  localparam int CB_SUMOUT   = 7;
  localparam int CB_SUB      = 6;
  localparam int CB_BWA      = 5;
  localparam int CB_OUTREGWA = 4;
  localparam int CB_PCINC    = 3;
  localparam int CB_PCOE     = 2;
  localparam int CB_PCJMP    = 1;
  localparam int CB_FLAGSIN  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Microcode words; the comment lists the asserted strobes.
  localparam logic [CW_WIDTH-1:0] CW_FETCH0  = 16'h4004; // marwa pcoe
  localparam logic [CW_WIDTH-1:0] CW_FETCH1  = 16'h1408; // ramoa inregwa pcinc
  localparam logic [CW_WIDTH-1:0] CW_IR_MAR  = 16'h4800; // marwa inregoa
  localparam logic [CW_WIDTH-1:0] CW_RAM_A   = 16'h1200; // ramoa awa
  localparam logic [CW_WIDTH-1:0] CW_RAM_B   = 16'h1020; // ramoa bwa
  localparam logic [CW_WIDTH-1:0] CW_ADD_A   = 16'h0281; // awa sumout flagsin
  localparam logic [CW_WIDTH-1:0] CW_SUB_A   = 16'h02C1; // awa sumout sub flagsin
  localparam logic [CW_WIDTH-1:0] CW_A_RAM   = 16'h2100; // ramwa aoa
  localparam logic [CW_WIDTH-1:0] CW_IR_A    = 16'h0A00; // inregoa awa
  localparam logic [CW_WIDTH-1:0] CW_JUMP    = 16'h0802; // inregoa pcjmp
  localparam logic [CW_WIDTH-1:0] CW_A_OUT   = 16'h0110; // aoa outregwa
  localparam logic [CW_WIDTH-1:0] CW_HALT    = 16'h8000; // hlt

  typedef struct packed {
    logic                end_;
    logic [CW_WIDTH-1:0] cw;
  } uop_t;

endpackage

// File: rtl/microseq_rom.sv
// Combinational microcode ROM: (opcode, step, cf, zf) -> {end_, cw} plus an undefined-opcode flag.
// Unreachable (opcode, step) pairs return an empty word with END so the sequencer always recovers.
module microseq_rom
  import microseq_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int STEPW = 3
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [STEPW-1:0] step,
  input  logic             cf,
  input  logic             zf,
  output uop_t             uop,
  output logic             illegal
);

  logic [3:0] op;
  assign op = 4'(opcode);

  always_comb begin
    uop.end_ = 1'b0;
    uop.cw   = '0;
    illegal  = 1'b0;
    case (int'(step))
      0: uop.cw = CW_FETCH0;
      1: uop.cw = CW_FETCH1;
      2: begin
        case (op)
          OP_NOP: uop.end_ = 1'b1;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: uop.cw = CW_IR_MAR;
          OP_LDI: begin uop.cw = CW_IR_A;  uop.end_ = 1'b1; end
          OP_JMP: begin uop.cw = CW_JUMP;  uop.end_ = 1'b1; end
          OP_JC:  begin uop.cw = cf ? CW_JUMP : '0; uop.end_ = 1'b1; end
          OP_JZ:  begin uop.cw = zf ? CW_JUMP : '0; uop.end_ = 1'b1; end
          OP_OUT: begin uop.cw = CW_A_OUT; uop.end_ = 1'b1; end
          // No END: the top level freezes the step counter on HLT.
          OP_HLT: uop.cw = CW_HALT;
          default: begin
            illegal  = 1'b1;
            uop.end_ = 1'b1;
          end
        endcase
      end
      3: begin
        case (op)
          OP_LDA:         begin uop.cw = CW_RAM_A; uop.end_ = 1'b1; end
          OP_ADD, OP_SUB: uop.cw = CW_RAM_B;
          OP_STA:         begin uop.cw = CW_A_RAM; uop.end_ = 1'b1; end
          default:        uop.end_ = 1'b1;
        endcase
      end
      4: begin
        uop.end_ = 1'b1;
        case (op)
          OP_ADD:  uop.cw = CW_ADD_A;
          OP_SUB:  uop.cw = CW_SUB_A;
          default: uop.cw = '0;
        endcase
      end
      default: uop.end_ = 1'b1;
    endcase
  end

endmodule

// File: rtl/microseq_ctrl.sv
// Microsequencer top: step counter, sticky halt, illegal pulse, run gating and optional CF/ZF shadows.
// Build macro MICROSEQ_FLAG_LATCH_EN: when defined, JC/JZ branch on flags captured at the last flagsin strobe.
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int STEPW  = 3,
  parameter int NSTEPS = 5,
  parameter int CWW    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [OPW-1:0]   opcode,
  input  logic             cf,
  input  logic             zf,
  output logic [CWW-1:0]   ctrl,
  output logic [STEPW-1:0] step,
  output logic             halted,
  output logic             illegal
);

  uop_t                uop;
  logic                rom_illegal;
  logic [CW_WIDTH-1:0] cw;
  logic [STEPW-1:0]    step_nxt;
  logic                br_cf;
  logic                br_zf;

`ifdef MICROSEQ_FLAG_LATCH_EN
  logic cf_q;
  logic zf_q;

  // Shadows follow the gated word, so a stalled or halted cycle never loads them.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (cw[CB_FLAGSIN]) begin
      cf_q <= cf;
      zf_q <= zf;
    end
  end

  assign br_cf = cf_q;
  assign br_zf = zf_q;
`else
  assign br_cf = cf;
  assign br_zf = zf;
`endif

  microseq_rom #(
    .OPW   (OPW),
    .STEPW (STEPW)
  ) u_rom (
    .opcode  (opcode),
    .step    (step),
    .cf      (br_cf),
    .zf      (br_zf),
    .uop     (uop),
    .illegal (rom_illegal)
  );

  always_comb begin
    cw = '0;
    if (halted) begin
      cw = CW_HALT;
    end else if (run) begin
      cw = uop.cw;
    end
  end

  assign ctrl = CWW'(cw);

  always_comb begin
    step_nxt = step;
    if (!halted && run && !uop.cw[CB_HLT]) begin
      if (uop.end_ || (int'(step) + 1 == NSTEPS)) begin
        step_nxt = '0;
      end else begin
        step_nxt = step + STEPW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      step    <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      step    <= step_nxt;
      halted  <= halted | (run & uop.cw[CB_HLT]);
      illegal <= run & ~halted & rom_illegal;
    end
  end

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl: fetch/execute sequences, branches, stall, illegal, halt and async clear.
// Honours MICROSEQ_FLAG_LATCH_EN to select the shadow-flag branch expectations.
module tb_microseq_ctrl;

  logic        clk;
  logic        clr;
  logic        run;
  logic [3:0]  opcode;
  logic        cf;
  logic        zf;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;
  logic        illegal;

  int n_cmp;
  int n_bad;

  microseq_ctrl #(
    .OPW    (4),
    .STEPW  (3),
    .NSTEPS (5),
    .CWW    (16)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .run     (run),
    .opcode  (opcode),
    .cf      (cf),
    .zf      (zf),
    .ctrl    (ctrl),
    .step    (step),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from step 0, checking step/ctrl/illegal for each of its n cycles.
  task automatic instr(input logic [3:0] op, input int n,
                       input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                       input logic [15:0] c3, input logic [15:0] c4);
    logic [15:0] cw [5];
    cw[0] = c0; cw[1] = c1; cw[2] = c2; cw[3] = c3; cw[4] = c4;
    opcode = op;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("op%0h_s%0d_step", op, i), 32'(step), 32'(i));
      chk($sformatf("op%0h_s%0d_ctrl", op, i), 32'(ctrl), 32'(cw[i]));
      chk($sformatf("op%0h_s%0d_illegal", op, i), 32'(illegal), 32'h0);
      tick();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clr    = 1'b1;
    run    = 1'b0;
    opcode = 4'h0;
    cf     = 1'b0;
    zf     = 1'b0;

    // Reset state
    #2;
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_illegal", 32'(illegal), 32'h0);
    chk("rst_ctrl_stalled", 32'(ctrl), 32'h0);
    run = 1'b1;
    #1;
    chk("rst_ctrl_run", 32'(ctrl), 32'h4004);
    tick();
    chk("rst_hold_step", 32'(step), 32'h0);
    clr = 1'b0;

    // LDA, ADD, SUB
    instr(4'h1, 4, 16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000);
    instr(4'h2, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281);
    instr(4'h3, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1);
    #1;
    chk("after_sub_step", 32'(step), 32'h0);

    // Single-step execute opcodes
    instr(4'h0, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000);
    instr(4'h4, 4, 16'h4004, 16'h1408, 16'h4800, 16'h2100, 16'h0000);
    instr(4'h5, 3, 16'h4004, 16'h1408, 16'h0A00, 16'h0000, 16'h0000);
    instr(4'h6, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000);
    instr(4'hE, 3, 16'h4004, 16'h1408, 16'h0110, 16'h0000, 16'h0000);

    // Conditional branches
`ifdef MICROSEQ_FLAG_LATCH_EN
    cf = 1'b1;
    instr(4'h7, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000);
    instr(4'h2, 5, 16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281);
    cf = 1'b0;
    instr(4'h7, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000);
`else
    cf = 1'b1;
    instr(4'h7, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000);
    cf = 1'b0;
    instr(4'h7, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000);
    zf = 1'b1;
    instr(4'h8, 3, 16'h4004, 16'h1408, 16'h0802, 16'h0000, 16'h0000);
    zf = 1'b0;
    instr(4'h8, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000);
`endif

    // Stall at LDA step 2
    opcode = 4'h1;
    tick();
    tick();
    #1;
    chk("stall_pre_ctrl", 32'(ctrl), 32'h4800);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_ctrl", i), 32'(ctrl), 32'h0);
      chk($sformatf("stall%0d_step", i), 32'(step), 32'h2);
      tick();
    end
    run = 1'b1;
    #1;
    chk("resume_s2_ctrl", 32'(ctrl), 32'h4800);
    tick();
    #1;
    chk("resume_s3_ctrl", 32'(ctrl), 32'h1200);
    chk("resume_s3_step", 32'(step), 32'h3);
    tick();
    #1;
    chk("resume_end_step", 32'(step), 32'h0);

    // Illegal opcode 1010
    opcode = 4'hA;
    tick();
    tick();
    #1;
    chk("ill_s2_ctrl", 32'(ctrl), 32'h0);
    chk("ill_s2_pulse_pre", 32'(illegal), 32'h0);
    tick();
    #1;
    chk("ill_pulse", 32'(illegal), 32'h1);
    chk("ill_step0", 32'(step), 32'h0);
    chk("ill_next_fetch", 32'(ctrl), 32'h4004);
    tick();
    #1;
    chk("ill_pulse_end", 32'(illegal), 32'h0);
    chk("ill_step1", 32'(step), 32'h1);
    opcode = 4'h0;
    tick();
    tick();

    // Mid-instruction clear
    opcode = 4'h2;
    tick();
    tick();
    tick();
    chk("midclr_pre_step", 32'(step), 32'h3);
    #3;
    clr = 1'b1;
    #1;
    chk("midclr_step", 32'(step), 32'h0);
    chk("midclr_ctrl", 32'(ctrl), 32'h4004);
    tick();
    clr = 1'b0;
    instr(4'h1, 4, 16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000);

    // HLT: stalled decode first, then halt and freeze
    opcode = 4'hF;
    tick();
    tick();
    run = 1'b0;
    #1;
    chk("hlt_stall_ctrl", 32'(ctrl), 32'h0);
    tick();
    chk("hlt_stall_halted", 32'(halted), 32'h0);
    chk("hlt_stall_step", 32'(step), 32'h2);
    run = 1'b1;
    #1;
    chk("hlt_s2_ctrl", 32'(ctrl), 32'h8000);
    tick();
    chk("hlt_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 22; i++) begin
      run    = i[0];
      opcode = 4'(i);
      #1;
      chk($sformatf("hlt%0d_ctrl", i), 32'(ctrl), 32'h8000);
      chk($sformatf("hlt%0d_step", i), 32'(step), 32'h2);
      chk($sformatf("hlt%0d_halted", i), 32'(halted), 32'h1);
      tick();
    end
    run = 1'b1;
    #3;
    clr = 1'b1;
    #1;
    chk("hltclr_halted", 32'(halted), 32'h0);
    chk("hltclr_step", 32'(step), 32'h0);
    chk("hltclr_ctrl", 32'(ctrl), 32'h4004);
    tick();
    clr = 1'b0;
    instr(4'h0, 3, 16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
